// File: rtl/esfa_vec_pkg.sv
// rtl/esfa_vec_pkg.sv - shared ESFA test-vector layout and trace FSM state encoding
//
// Purpose: single source of truth for the 64-bit ESFA test-vector word, shared
//          by the trace writer (producer) and the self-check runner (consumer).
// Ports:   none (package).
package esfa_vec_pkg;

    localparam int VEC_W   = 64;
    localparam int FIELD_W = 8;

    // Flag bits in the low byte; [7:3] are reserved and always zero.
    localparam int BIT_MUT       = 0;
    localparam int BIT_EXP_BOOL  = 1;
    localparam int BIT_EOP       = 2;

    // Byte-wide fields; [63:48] are reserved and always zero.
    localparam int HANDLE_LSB    = 8;
    localparam int NEW_INDEX_LSB = 16;
    localparam int NEW_VALUE_LSB = 24;
    localparam int SELECTOR_LSB  = 32;
    localparam int EXP_VALUE_LSB = 40;

    localparam logic [VEC_W-1:0] END_MARKER_WORD = 64'h4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_WAIT,
        ST_WRITE,
        ST_TERM,
        ST_DONE
    } trace_state_e;

endpackage

// File: rtl/esfa_vector_pack.sv
// rtl/esfa_vector_pack.sv - combinational packer for one 64-bit ESFA test vector
//
// Purpose: assemble stimulus fields and flags into the ROM vector format.
// Ports:   is_mutating_i, end_of_program_i, result_bool_i  - flag inputs
//          handle_i, new_index_i, new_value_i, selector_i  - stimulus bytes
//          result_value_i                                  - expected value byte
//          word_o                                          - packed vector
module esfa_vector_pack
    import esfa_vec_pkg::*;
(
    input  logic               is_mutating_i,
    input  logic               end_of_program_i,
    input  logic               result_bool_i,
    input  logic [FIELD_W-1:0] handle_i,
    input  logic [FIELD_W-1:0] new_index_i,
    input  logic [FIELD_W-1:0] new_value_i,
    input  logic [FIELD_W-1:0] selector_i,
    input  logic [FIELD_W-1:0] result_value_i,
    output logic [VEC_W-1:0]   word_o
);

    always_comb begin
        word_o                               = '0;
        word_o[BIT_MUT]                      = is_mutating_i;
        word_o[BIT_EOP]                      = end_of_program_i;
        word_o[HANDLE_LSB    +: FIELD_W]     = handle_i;
        word_o[NEW_INDEX_LSB +: FIELD_W]     = new_index_i;
        word_o[NEW_VALUE_LSB +: FIELD_W]     = new_value_i;
        word_o[SELECTOR_LSB  +: FIELD_W]     = selector_i;
        // Mutating operations carry no meaningful result; the runner expects zeros.
        if (!is_mutating_i) begin
            word_o[BIT_EXP_BOOL]                 = result_bool_i;
            word_o[EXP_VALUE_LSB +: FIELD_W]     = result_value_i;
        end
    end

endmodule

// File: rtl/esfa_trace_writer.sv
// rtl/esfa_trace_writer.sv - records ESFA stimulus/response pairs into BRAM as test vectors
//
// Purpose: capture accepted stimuli plus the ESFADesign result that follows
//          RESULT_LATENCY cycles later, write them as 64-bit vectors from
//          address 0, and close the image with an end-of-program word.
// Ports:   clk, reset                      - clock, synchronous active-high reset
//          start, stop                     - recording control pulses
//          in_valid / in_ready             - stimulus handshake
//          is_mutating, queried_handle, new_index, new_value, selector - stimulus
//          result_bool, result_value       - ESFADesign response
//          mem_we, mem_addr, mem_wdata     - BRAM write port
//          busy, done, overflow, vector_count - status
module esfa_trace_writer
    import esfa_vec_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 256,
    parameter int ADDR_STEP      = 8,
    parameter int RESULT_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     is_mutating,
    input  logic [7:0]               queried_handle,
    input  logic [7:0]               new_index,
    input  logic [7:0]               new_value,
    input  logic [7:0]               selector,
    input  logic                     result_bool,
    input  logic [7:0]               result_value,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [63:0]              mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH)-1:0] vector_count
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam int LAT_W = $clog2(RESULT_LATENCY + 1);
    // Last slot is reserved for the end marker, so vectors stop one short of DEPTH.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    trace_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic                stop_pend_q, stop_pend_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                mut_q, mut_d;
    logic [7:0]          handle_q, handle_d;
    logic [7:0]          index_q, index_d;
    logic [7:0]          value_q, value_d;
    logic [7:0]          sel_q, sel_d;
    logic                rbool_q, rbool_d;
    logic [7:0]          rval_q, rval_d;

    logic [CNT_W-1:0]    count_inc;
    logic                stop_now;
    logic                at_capacity;
    logic [63:0]         packed_word;

    assign count_inc   = count_q + CNT_W'(1);
    assign stop_now    = stop_pend_q || stop;
    assign at_capacity = (count_inc == LAST_CNT);

    esfa_vector_pack u_pack (
        .is_mutating_i    (mut_q),
        .end_of_program_i (1'b0),
        .result_bool_i    (rbool_q),
        .handle_i         (handle_q),
        .new_index_i      (index_q),
        .new_value_i      (value_q),
        .selector_i       (sel_q),
        .result_value_i   (rval_q),
        .word_o           (packed_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            lat_q       <= '0;
            mut_q       <= 1'b0;
            handle_q    <= '0;
            index_q     <= '0;
            value_q     <= '0;
            sel_q       <= '0;
            rbool_q     <= 1'b0;
            rval_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            stop_pend_q <= stop_pend_d;
            lat_q       <= lat_d;
            mut_q       <= mut_d;
            handle_q    <= handle_d;
            index_q     <= index_d;
            value_q     <= value_d;
            sel_q       <= sel_d;
            rbool_q     <= rbool_d;
            rval_q      <= rval_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        stop_pend_d = stop_pend_q;
        lat_d       = lat_q;
        mut_d       = mut_q;
        handle_d    = handle_q;
        index_d     = index_q;
        value_d     = value_q;
        sel_d       = sel_q;
        rbool_d     = rbool_q;
        rval_d      = rval_q;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_ARMED;
                    addr_d      = '0;
                    count_d     = '0;
                    done_d      = 1'b0;
                    overflow_d  = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            ST_ARMED: begin
                in_ready = (count_q < LAST_CNT);
                if (in_valid && in_ready) begin
                    mut_d       = is_mutating;
                    handle_d    = queried_handle;
                    index_d     = new_index;
                    value_d     = new_value;
                    sel_d       = selector;
                    lat_d       = LAT_W'(RESULT_LATENCY);
                    // A stop coinciding with acceptance closes the trace after this vector.
                    stop_pend_d = stop;
                    state_d     = ST_WAIT;
                end else if (stop) begin
                    state_d = ST_TERM;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (lat_q == LAT_W'(1)) begin
                    rbool_d = result_bool;
                    rval_d  = result_value;
                    state_d = ST_WRITE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_WRITE: begin
                mem_we      = 1'b1;
                mem_wdata   = packed_word;
                addr_d      = addr_q + ADDR_W'(ADDR_STEP);
                count_d     = count_inc;
                stop_pend_d = 1'b0;
                if (stop_now || at_capacity) begin
                    state_d    = ST_TERM;
                    // A requested stop takes precedence over reporting a full trace.
                    overflow_d = at_capacity && !stop_now;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_TERM: begin
                mem_we    = 1'b1;
                mem_wdata = END_MARKER_WORD;
                done_d    = 1'b1;
                state_d   = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr     = addr_q;
    assign busy         = (state_q == ST_ARMED) || (state_q == ST_WAIT) ||
                          (state_q == ST_WRITE) || (state_q == ST_TERM);
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign vector_count = count_q;

endmodule

// File: tb/tb_esfa_trace_writer.sv
// tb/tb_esfa_trace_writer.sv - self-checking bench for esfa_trace_writer
module tb_esfa_trace_writer;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int STEP   = 8;
    localparam int RL     = 2;

    logic              clk = 1'b0;
    logic              reset, start, stop, in_valid, in_ready;
    logic              is_mutating, result_bool;
    logic [7:0]        queried_handle, new_index, new_value, selector, result_value;
    logic              mem_we, busy, done, overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [1:0]        vector_count;

    esfa_trace_writer #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ADDR_STEP(STEP), .RESULT_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .is_mutating(is_mutating),
        .queried_handle(queried_handle), .new_index(new_index), .new_value(new_value),
        .selector(selector), .result_bool(result_bool), .result_value(result_value),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .vector_count(vector_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        int          land;
    } wr_t;
    wr_t wq[$];

    // land = index of the clock edge on which the BRAM captures the write
    always @(negedge clk) begin
        if (mem_we) wq.push_back('{mem_addr, mem_wdata, cyc + 1});
    end

    typedef struct {
        logic       mut;
        logic [7:0] h, i, v, s;
        logic       rb;
        logic [7:0] rv;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[5];
    int   tests = 0;
    int   fails = 0;
    int   acc_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_write(input string name, input int k, input logic [31:0] a,
                             input logic [63:0] d);
        chk({name, "_present"}, 64'(wq.size() > k), 64'd1);
        if (wq.size() > k) begin
            chk({name, "_addr"}, 64'(wq[k].addr), 64'(a));
            chk({name, "_data"}, wq[k].data, d);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin step(); n++; end
        chk("done_wait", 64'(done), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_count"}, 64'(vector_count), 64'd0);
    endtask

    // Drives the result as the inverse of the true one except on the edge
    // exactly RL cycles after acceptance, so a latency slip corrupts the word.
    task automatic send_vec(input vec_t v, input logic with_stop);
        is_mutating = v.mut; queried_handle = v.h; new_index = v.i;
        new_value = v.v; selector = v.s;
        result_bool = ~v.rb; result_value = ~v.rv;
        in_valid = 1'b1; stop = with_stop;
        step();
        acc_cyc = cyc;
        in_valid = 1'b0; stop = 1'b0;
        repeat (RL - 1) step();
        result_bool = v.rb; result_value = v.rv;
        step();
        result_bool = ~v.rb; result_value = ~v.rv;
    endtask

    initial begin
        tbl[0] = '{1'b0, 8'h03, 8'h01, 8'h2A, 8'h02, 1'b1, 8'h2A, 64'h0000_2A02_2A01_0302};
        tbl[1] = '{1'b1, 8'h03, 8'h01, 8'h2A, 8'h02, 1'b1, 8'hFF, 64'h0000_0002_2A01_0301};
        tbl[2] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 64'h0000_00FF_FFFF_FF00};
        tbl[3] = '{1'b0, 8'hA5, 8'h3C, 8'hC3, 8'h81, 1'b0, 8'h5A, 64'h0000_5A81_C33C_A500};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 64'h0000_0000_0000_0002};

        reset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        is_mutating = 1'b0; queried_handle = '0; new_index = '0; new_value = '0;
        selector = '0; result_bool = 1'b0; result_value = '0;
        step(); step();
        check_reset_outputs("por");
        reset = 1'b0;
        step();

        // stop while idle: no write, no state change
        wq.delete();
        pulse_stop();
        repeat (3) step();
        chk("idle_stop_writes", 64'(wq.size()), 64'd0);
        chk("idle_stop_busy", 64'(busy), 64'd0);
        chk("idle_stop_done", 64'(done), 64'd0);

        // single-vector recordings from the table
        for (int k = 0; k < 5; k++) begin
            wq.delete();
            pulse_start();
            chk($sformatf("t%0d_busy", k), 64'(busy), 64'd1);
            send_vec(tbl[k], 1'b0);
            wait_ready();
            pulse_stop();
            wait_done();
            chk_write($sformatf("t%0d_vec", k), 0, 32'd0, tbl[k].exp);
            if (wq.size() > 0)
                chk($sformatf("t%0d_land", k), 64'(wq[0].land), 64'(acc_cyc + RL + 1));
            chk_write($sformatf("t%0d_end", k), 1, 32'd8, 64'h4);
            chk($sformatf("t%0d_nwr", k), 64'(wq.size()), 64'd2);
            chk($sformatf("t%0d_count", k), 64'(vector_count), 64'd1);
            chk($sformatf("t%0d_ovf", k), 64'(overflow), 64'd0);
            chk($sformatf("t%0d_busy_end", k), 64'(busy), 64'd0);
        end

        // stop together with an accepted vector
        wq.delete();
        pulse_start();
        send_vec(tbl[3], 1'b1);
        wait_done();
        chk_write("same_stop_vec", 0, 32'd0, tbl[3].exp);
        chk_write("same_stop_end", 1, 32'd8, 64'h4);
        chk("same_stop_nwr", 64'(wq.size()), 64'd2);
        chk("same_stop_count", 64'(vector_count), 64'd1);

        // fill to capacity, with a start pulse while busy that must be ignored
        wq.delete();
        pulse_start();
        send_vec(tbl[0], 1'b0);
        wait_ready();
        send_vec(tbl[1], 1'b0);
        pulse_start();
        wait_ready();
        send_vec(tbl[3], 1'b0);
        wait_done();
        chk_write("fill_v0", 0, 32'd0, tbl[0].exp);
        chk_write("fill_v1", 1, 32'd8, tbl[1].exp);
        chk_write("fill_v2", 2, 32'd16, tbl[3].exp);
        chk_write("fill_end", 3, 32'd24, 64'h4);
        chk("fill_nwr", 64'(wq.size()), 64'd4);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_count", 64'(vector_count), 64'd3);
        chk("fill_in_ready", 64'(in_ready), 64'd0);

        // restart after DONE clears status
        wq.delete();
        pulse_start();
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_ovf", 64'(overflow), 64'd0);
        chk("restart_count", 64'(vector_count), 64'd0);
        chk("restart_addr", 64'(mem_addr), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        pulse_stop();
        wait_done();
        chk_write("empty_end", 0, 32'd0, 64'h4);
        chk("empty_nwr", 64'(wq.size()), 64'd1);

        // reset while a vector waits for its result
        wq.delete();
        pulse_start();
        send_vec(tbl[0], 1'b0);
        wait_ready();
        is_mutating = 1'b0; queried_handle = 8'h11; new_index = 8'h22;
        new_value = 8'h33; selector = 8'h44;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rst_pre_addr", 64'(mem_addr), 64'd8);
        reset = 1'b1;
        begin
            int n0;
            n0 = wq.size();
            step();
            check_reset_outputs("midrst");
            reset = 1'b0;
            repeat (5) step();
            chk("midrst_no_write", 64'(wq.size()), 64'(n0));
        end
        wq.delete();
        pulse_start();
        send_vec(tbl[2], 1'b0);
        wait_ready();
        pulse_stop();
        wait_done();
        chk_write("post_rst_vec", 0, 32'd0, tbl[2].exp);
        chk_write("post_rst_end", 1, 32'd8, 64'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
